// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer.
// Drives a 1-cycle-latency instruction memory and presents each fetched word
// on a valid/ready output. Supports stall replay, redirects and halting.
// The sequencer starts in IDLE and only begins fetching when start is pulsed.
module fetch_sequencer #(
    parameter logic [9:0]  RESET_PC   = 10'd0,
    parameter logic [9:0]  PC_LAST    = 10'd1023,
    parameter logic [31:0] HALT_INSTR = 32'h00000073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [9:0]  mem_addr,
    input  logic [31:0] mem_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [9:0]  out_pc,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [9:0]  fetch_pc;
    logic [9:0]  fetch_pc_next;
    logic [9:0]  rsp_pc;
    logic [9:0]  rsp_pc_next;
    logic        rsp_valid;
    logic        rsp_valid_next;
    logic [15:0] count_next;
    logic        transfer;
    logic        halt_hit;

    // The accepted-instruction counter stops at its maximum value
    // instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        if (value == 16'hFFFF) begin
            sat_inc = 16'hFFFF;
        end else begin
            sat_inc = value + 16'd1;
        end
    endfunction

    // The memory word arrives one cycle after its address was sent,
    // so it lines up with rsp_pc.
    assign out_instr = mem_instr;
    assign out_pc    = rsp_pc;
    // A redirect kills the word being presented in the same cycle.
    assign out_valid = rsp_valid & (state == ST_RUN) & ~redirect;
    assign transfer  = out_valid & out_ready;
    assign halted    = (state == ST_HALT);
    assign halt_hit  = (rsp_pc == PC_LAST) | (mem_instr == HALT_INSTR);

    // Next-state, next-register and memory-address selection.
    always_comb begin
        state_next     = state;
        fetch_pc_next  = fetch_pc;
        rsp_pc_next    = rsp_pc;
        rsp_valid_next = rsp_valid;
        count_next     = instr_count;
        mem_addr       = RESET_PC;
        case (state)
            ST_IDLE, ST_HALT: begin
                mem_addr = RESET_PC;
                if (start) begin
                    state_next     = ST_RUN;
                    rsp_pc_next    = RESET_PC;
                    rsp_valid_next = 1'b1;
                    fetch_pc_next  = RESET_PC + 10'd1;
                    count_next     = 16'd0;
                end else begin
                    state_next = state;
                end
            end
            ST_RUN: begin
                if (redirect) begin
                    // Redirect wins over stall and halt detection.
                    mem_addr       = redirect_pc;
                    rsp_pc_next    = redirect_pc;
                    rsp_valid_next = 1'b1;
                    fetch_pc_next  = redirect_pc + 10'd1;
                end else if (rsp_valid && !out_ready) begin
                    // Stall: re-read the held address so the word stays put.
                    mem_addr = rsp_pc;
                end else begin
                    mem_addr       = fetch_pc;
                    rsp_pc_next    = fetch_pc;
                    rsp_valid_next = 1'b1;
                    fetch_pc_next  = fetch_pc + 10'd1;
                    if (transfer) begin
                        count_next = sat_inc(instr_count);
                        if (halt_hit) begin
                            // Drop the word fetched speculatively behind the halt.
                            state_next     = ST_HALT;
                            rsp_valid_next = 1'b0;
                        end else begin
                            state_next = ST_RUN;
                        end
                    end else begin
                        count_next = instr_count;
                    end
                end
            end
            default: begin
                state_next     = ST_IDLE;
                fetch_pc_next  = RESET_PC;
                rsp_pc_next    = RESET_PC;
                rsp_valid_next = 1'b0;
                count_next     = 16'd0;
                mem_addr       = RESET_PC;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Fetch pointers, response tracking and instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rsp_valid   <= 1'b0;
            instr_count <= 16'd0;
        end else begin
            fetch_pc    <= fetch_pc_next;
            rsp_pc      <= rsp_pc_next;
            rsp_valid   <= rsp_valid_next;
            instr_count <= count_next;
        end
    end

endmodule
